// File: rtl/life_8x8_engine_pkg.sv
// Shared types and constants for the 8x8 Game-of-Life frame generator.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT
    } state_t;

    localparam int unsigned GRID_N    = 8;
    localparam int unsigned CELLS     = 64;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned ROW_SHIFT = 3;
    localparam logic [5:0]  COL_MASK  = 6'd7;

    localparam logic [8:0] LIFE_BIRTH   = 9'b000001000;
    localparam logic [8:0] LIFE_SURVIVE = 9'b000001100;

    function automatic logic [2:0] idx_row(input logic [IDX_W-1:0] i);
        return 3'(i >> ROW_SHIFT);
    endfunction

    function automatic logic [2:0] idx_col(input logic [IDX_W-1:0] i);
        return 3'(i & COL_MASK);
    endfunction

endpackage

// File: rtl/life_8x8_engine_if.sv
// Seed/step control and frame/status bus between the engine and its host.
interface life_8x8_engine_if #(
    parameter int unsigned GEN_W = 16
);
    logic             seed_valid;
    logic [63:0]      seed_data;
    logic             step;
    logic             busy;
    logic             done;
    logic [63:0]      frame;
    logic             empty;
    logic             stagnant;
    logic [GEN_W-1:0] generation;

    modport master (
        output seed_valid, seed_data, step,
        input  busy, done, frame, empty, stagnant, generation
    );

    modport slave (
        input  seed_valid, seed_data, step,
        output busy, done, frame, empty, stagnant, generation
    );
endinterface

// File: rtl/life_8x8_engine_cell_rule.sv
// Combinational neighbour count and next-state rule for one cell of the frame.
module life_cell_rule
    import life_pkg::*;
#(
    parameter bit         WRAP         = 1'b1,
    parameter logic [8:0] BIRTH_MASK   = LIFE_BIRTH,
    parameter logic [8:0] SURVIVE_MASK = LIFE_SURVIVE
) (
    input  logic [63:0]      i_frame,
    input  logic [IDX_W-1:0] i_idx,
    output logic [3:0]       o_count,
    output logic             o_next
);

    localparam logic [2:0] LAST = 3'(GRID_N - 1);

    logic [2:0] w_row;
    logic [2:0] w_col;
    logic [2:0] w_rows [3];
    logic [2:0] w_cols [3];
    logic       w_rv   [3];
    logic       w_cv   [3];

    always_comb begin
        w_row = idx_row(i_idx);
        w_col = idx_col(i_idx);

        // 3-bit arithmetic wraps naturally; the valid flags mask it off at the edges when not toroidal
        w_rows[0] = w_row - 3'd1;
        w_rows[1] = w_row;
        w_rows[2] = w_row + 3'd1;
        w_cols[0] = w_col - 3'd1;
        w_cols[1] = w_col;
        w_cols[2] = w_col + 3'd1;

        w_rv[0] = WRAP || (w_row != '0);
        w_rv[1] = 1'b1;
        w_rv[2] = WRAP || (w_row != LAST);
        w_cv[0] = WRAP || (w_col != '0);
        w_cv[1] = 1'b1;
        w_cv[2] = WRAP || (w_col != LAST);

        o_count = '0;
        for (int unsigned a = 0; a < 3; a++) begin
            for (int unsigned b = 0; b < 3; b++) begin
                if (!(a == 1 && b == 1) && w_rv[a] && w_cv[b]) begin
                    o_count = o_count + 4'(i_frame[{w_rows[a], w_cols[b]}]);
                end
            end
        end

        o_next = i_frame[i_idx] ? SURVIVE_MASK[o_count] : BIRTH_MASK[o_count];
    end

endmodule

// File: rtl/life_8x8_engine.sv
// Serial Game-of-Life engine: one cell per clock into a shadow frame, committed atomically.
module life_8x8_engine
    import life_pkg::*;
#(
    parameter bit          WRAP         = 1'b1,
    parameter logic [8:0]  BIRTH_MASK   = LIFE_BIRTH,
    parameter logic [8:0]  SURVIVE_MASK = LIFE_SURVIVE,
    parameter int unsigned GEN_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    life_8x8_engine_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [63:0]      r_frame;
    logic [63:0]      r_shadow;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_stagnant;
    logic [GEN_W-1:0] r_gen;
    logic [3:0]       w_count;
    logic             w_next_cell;

    life_cell_rule #(
        .WRAP         (WRAP),
        .BIRTH_MASK   (BIRTH_MASK),
        .SURVIVE_MASK (SURVIVE_MASK)
    ) u_rule (
        .i_frame (r_frame),
        .i_idx   (r_idx),
        .o_count (w_count),
        .o_next  (w_next_cell)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A seed load pre-empts everything, including an in-flight generation
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!bus.seed_valid && bus.step) w_next_state = CALC;
            CALC: begin
                if (bus.seed_valid)         w_next_state = IDLE;
                else if (r_idx == LAST_IDX) w_next_state = COMMIT;
            end
            COMMIT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame    <= '0;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_stagnant <= 1'b0;
            r_gen      <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.seed_valid) begin
                r_frame    <= bus.seed_data;
                r_gen      <= '0;
                r_stagnant <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.step) begin
                            r_idx  <= '0;
                            r_busy <= 1'b1;
                        end
                    end
                    CALC: begin
                        r_shadow[r_idx] <= w_next_cell;
                        r_idx           <= r_idx + 1'b1;
                    end
                    COMMIT: begin
                        r_frame    <= r_shadow;
                        r_stagnant <= (r_shadow == r_frame);
                        r_gen      <= r_gen + 1'b1;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.frame      = r_frame;
    assign bus.empty      = (r_frame == '0);
    assign bus.stagnant   = r_stagnant;
    assign bus.generation = r_gen;

endmodule

// File: tb/tb_life_8x8_engine.sv
// Directed-vector bench for life_8x8_engine (toroidal and bounded instances).
module tb_life_8x8_engine;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
    localparam logic [63:0] ROW0    = 64'h0000_0000_0000_0007;
    localparam logic [63:0] ROW0_W1 = 64'h0200_0000_0000_0202;
    localparam logic [63:0] ROW0_W0 = 64'h0000_0000_0000_0202;
    localparam logic [63:0] SINGLE  = 64'h0000_0000_1000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    life_8x8_engine_if #(.GEN_W(16)) b0 ();
    life_8x8_engine_if #(.GEN_W(16)) b1 ();

    life_8x8_engine #(
        .WRAP(1'b1), .BIRTH_MASK(9'b000001000), .SURVIVE_MASK(9'b000001100), .GEN_W(16)
    ) u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    life_8x8_engine #(
        .WRAP(1'b0), .BIRTH_MASK(9'b000001000), .SURVIVE_MASK(9'b000001100), .GEN_W(16)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    task automatic seed(input int sel, input logic [63:0] d);
        @(negedge clk);
        if (sel == 0) begin b0.seed_valid = 1'b1; b0.seed_data = d; end
        else          begin b1.seed_valid = 1'b1; b1.seed_data = d; end
        @(posedge clk);
        #1;
        b0.seed_valid = 1'b0;
        b1.seed_valid = 1'b0;
    endtask

    // Returns the number of edges after the step-sampling edge until done, or -1 on timeout
    task automatic run_step(input int sel, output int lat);
        @(negedge clk);
        if (sel == 0) b0.step = 1'b1; else b1.step = 1'b1;
        @(posedge clk);
        #1;
        b0.step = 1'b0;
        b1.step = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if ((sel == 0) ? b0.done : b1.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_vec++; if (b0.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", b0.done); end
            n_vec++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", b0.busy); end
        end
        n_vec++; if (b0.frame !== 64'h0) begin n_err++; $display("FAIL reset_frame got %h exp 0", b0.frame); end
        n_vec++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", b0.empty); end
        n_vec++; if (b0.generation !== 16'd0) begin n_err++; $display("FAIL reset_gen got %0d exp 0", b0.generation); end
        n_vec++; if (b0.stagnant !== 1'b0) begin n_err++; $display("FAIL reset_stag got %b exp 0", b0.stagnant); end
        n_vec++; if (b1.frame !== 64'h0) begin n_err++; $display("FAIL reset_frame1 got %h exp 0", b1.frame); end
    endtask

    task automatic test_blinker();
        int lat;
        seed(0, BLINK_H);
        n_vec++; if (b0.frame !== BLINK_H) begin n_err++; $display("FAIL seed_frame got %h exp %h", b0.frame, BLINK_H); end
        n_vec++; if (b0.empty !== 1'b0) begin n_err++; $display("FAIL seed_empty got %b exp 0", b0.empty); end
        run_step(0, lat);
        n_vec++; if (lat !== 65) begin n_err++; $display("FAIL blink_latency got %0d exp 65", lat); end
        n_vec++; if (b0.frame !== BLINK_V) begin n_err++; $display("FAIL blink_gen1 got %h exp %h", b0.frame, BLINK_V); end
        n_vec++; if (b0.generation !== 16'd1) begin n_err++; $display("FAIL blink_gen_cnt1 got %0d exp 1", b0.generation); end
        n_vec++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL blink_busy got %b exp 0", b0.busy); end
        @(posedge clk);
        #1;
        n_vec++; if (b0.done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got %b exp 0", b0.done); end
        run_step(0, lat);
        n_vec++; if (lat !== 65) begin n_err++; $display("FAIL blink_latency2 got %0d exp 65", lat); end
        n_vec++; if (b0.frame !== BLINK_H) begin n_err++; $display("FAIL blink_gen2 got %h exp %h", b0.frame, BLINK_H); end
        n_vec++; if (b0.generation !== 16'd2) begin n_err++; $display("FAIL blink_gen_cnt2 got %0d exp 2", b0.generation); end
        n_vec++; if (b0.stagnant !== 1'b0) begin n_err++; $display("FAIL blink_stag got %b exp 0", b0.stagnant); end
    endtask

    task automatic test_block();
        int lat;
        seed(0, BLOCK);
        n_vec++; if (b0.generation !== 16'd0) begin n_err++; $display("FAIL seed_gen_clear got %0d exp 0", b0.generation); end
        run_step(0, lat);
        n_vec++; if (b0.frame !== BLOCK) begin n_err++; $display("FAIL block_frame got %h exp %h", b0.frame, BLOCK); end
        n_vec++; if (b0.stagnant !== 1'b1) begin n_err++; $display("FAIL block_stag got %b exp 1", b0.stagnant); end
        n_vec++; if (b0.empty !== 1'b0) begin n_err++; $display("FAIL block_empty got %b exp 0", b0.empty); end
        n_vec++; if (b0.generation !== 16'd1) begin n_err++; $display("FAIL block_gen got %0d exp 1", b0.generation); end
    endtask

    task automatic test_wrap();
        int lat;
        seed(0, ROW0);
        seed(1, ROW0);
        n_vec++; if (b0.stagnant !== 1'b0) begin n_err++; $display("FAIL seed_stag_clear got %b exp 0", b0.stagnant); end
        run_step(0, lat);
        n_vec++; if (b0.frame !== ROW0_W1) begin n_err++; $display("FAIL wrap1_frame got %h exp %h", b0.frame, ROW0_W1); end
        run_step(1, lat);
        n_vec++; if (lat !== 65) begin n_err++; $display("FAIL wrap0_latency got %0d exp 65", lat); end
        n_vec++; if (b1.frame !== ROW0_W0) begin n_err++; $display("FAIL wrap0_frame got %h exp %h", b1.frame, ROW0_W0); end
    endtask

    task automatic test_single();
        int lat;
        seed(0, SINGLE);
        run_step(0, lat);
        n_vec++; if (b0.frame !== 64'h0) begin n_err++; $display("FAIL single_frame got %h exp 0", b0.frame); end
        n_vec++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL single_empty got %b exp 1", b0.empty); end
        n_vec++; if (b0.stagnant !== 1'b0) begin n_err++; $display("FAIL single_stag got %b exp 0", b0.stagnant); end
    endtask

    task automatic test_abort();
        bit saw_done = 1'b0;
        bit saw_busy = 1'b0;
        seed(0, BLINK_H);
        @(negedge clk);
        b0.step = 1'b1;
        @(posedge clk);
        #1;
        b0.step = 1'b0;
        repeat (28) @(posedge clk);
        @(negedge clk);
        b0.step = 1'b1;
        @(posedge clk);
        #1;
        b0.step = 1'b0;
        n_vec++; if (b0.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_mid got %b exp 1", b0.busy); end
        n_vec++; if (b0.frame !== BLINK_H) begin n_err++; $display("FAIL abort_frame_mid got %h exp %h", b0.frame, BLINK_H); end
        @(negedge clk);
        b0.seed_valid = 1'b1;
        b0.seed_data  = BLOCK;
        @(posedge clk);
        #1;
        b0.seed_valid = 1'b0;
        n_vec++; if (b0.frame !== BLOCK) begin n_err++; $display("FAIL abort_frame got %h exp %h", b0.frame, BLOCK); end
        n_vec++; if (b0.generation !== 16'd0) begin n_err++; $display("FAIL abort_gen got %0d exp 0", b0.generation); end
        n_vec++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b exp 0", b0.busy); end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (b0.done) saw_done = 1'b1;
            if (b0.busy) saw_busy = 1'b1;
        end
        n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got %b exp 0", saw_done); end
        n_vec++; if (saw_busy !== 1'b0) begin n_err++; $display("FAIL abort_step_dropped got %b exp 0", saw_busy); end
        n_vec++; if (b0.frame !== BLOCK) begin n_err++; $display("FAIL abort_frame_hold got %h exp %h", b0.frame, BLOCK); end
    endtask

    task automatic test_back_to_back();
        int first  = -1;
        int second = -1;
        seed(0, BLINK_H);
        @(negedge clk);
        b0.step = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (b0.done) begin
                if (first < 0) first = i;
                else begin
                    second = i;
                    break;
                end
            end
        end
        b0.step = 1'b0;
        n_vec++; if (first !== 66) begin n_err++; $display("FAIL b2b_first got %0d exp 66", first); end
        n_vec++; if (second - first !== 66) begin n_err++; $display("FAIL b2b_spacing got %0d exp 66", second - first); end
        n_vec++; if (b0.frame !== BLINK_H) begin n_err++; $display("FAIL b2b_frame got %h exp %h", b0.frame, BLINK_H); end
        n_vec++; if (b0.generation !== 16'd2) begin n_err++; $display("FAIL b2b_gen got %0d exp 2", b0.generation); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b exp 0", b0.busy); end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        seed(0, BLINK_H);
        @(negedge clk);
        b0.step = 1'b1;
        @(posedge clk);
        #1;
        b0.step = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++; if (b0.frame !== 64'h0) begin n_err++; $display("FAIL rstmid_frame got %h exp 0", b0.frame); end
        n_vec++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", b0.busy); end
        n_vec++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL rstmid_empty got %b exp 1", b0.empty); end
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (b0.done) saw_done = 1'b1;
        end
        n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done got %b exp 0", saw_done); end
    endtask

    initial begin
        rst           = 1'b1;
        b0.seed_valid = 1'b0;
        b0.seed_data  = '0;
        b0.step       = 1'b0;
        b1.seed_valid = 1'b0;
        b1.seed_data  = '0;
        b1.step       = 1'b0;
        test_reset();
        test_blinker();
        test_block();
        test_wrap();
        test_single();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
